// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed program image over a byte
// stream, writes it word by word into instruction memory, then releases the core.
//
// state   | meaning
// HDR_HI  | waiting for word count N[15:8]
// HDR_LO  | waiting for word count N[7:0], header sanity check
// PAYLOAD | assembling a 32-bit word, MSB byte first
// WRITE   | one-cycle imem write of the assembled word
// CHECK   | waiting for the XOR checksum byte
// DONE    | image good, core released (held until reset)
// ERROR   | bad header or checksum (held until reset)
module imem_boot_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  core_run,
   output logic                  load_done,
   output logic                  load_error
);

   typedef enum logic [2:0] {
      HDR_HI, HDR_LO, PAYLOAD, WRITE, CHECK, DONE, ERROR
   } state_t;

   localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

   state_t                state, state_nxt;
   logic [15:0]           n_words;
   logic [ADDR_WIDTH:0]   word_cnt;
   logic [1:0]            byte_idx;
   logic [7:0]            csum;
   logic [31:0]           word_buf;
   logic                  accept;
   logic [15:0]           hdr_n;
   logic                  hdr_bad;
   logic [16:0]           cnt_inc;

   always_comb begin
      rx_ready = 1'b0;
      if (reset_n) begin
         rx_ready = (state == HDR_HI) || (state == HDR_LO) ||
                    (state == PAYLOAD) || (state == CHECK);
      end
   end

   assign accept  = rx_valid && rx_ready;
   assign hdr_n   = {n_words[15:8], rx_data};
   assign hdr_bad = (hdr_n == 16'd0) || ({1'b0, hdr_n} > MAX_WORDS);
   // Counter is one bit wider than the address so a full-depth image ends cleanly.
   assign cnt_inc = 17'(word_cnt) + 17'd1;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= HDR_HI;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         HDR_HI:  if (accept) state_nxt = HDR_LO;
         HDR_LO:  if (accept) state_nxt = hdr_bad ? ERROR : PAYLOAD;
         PAYLOAD: if (accept && byte_idx == 2'd3) state_nxt = WRITE;
         WRITE:   state_nxt = (cnt_inc == {1'b0, n_words}) ? CHECK : PAYLOAD;
         CHECK:   if (accept) state_nxt = (rx_data == csum) ? DONE : ERROR;
         DONE:    state_nxt = DONE;
         ERROR:   state_nxt = ERROR;
         default: state_nxt = HDR_HI;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         n_words  <= 16'd0;
         word_cnt <= '0;
         byte_idx <= 2'd0;
         csum     <= 8'h00;
         word_buf <= 32'd0;
      end else begin
         case (state)
            HDR_HI:  if (accept) n_words[15:8] <= rx_data;
            HDR_LO:  if (accept) n_words[7:0]  <= rx_data;
            PAYLOAD: if (accept) begin
               word_buf <= {word_buf[23:0], rx_data};
               csum     <= csum ^ rx_data;
               byte_idx <= byte_idx + 2'd1;
            end
            WRITE:   word_cnt <= word_cnt + 1'b1;
            default: ;
         endcase
      end
   end

   assign imem_we    = (state == WRITE);
   assign imem_addr  = word_cnt[ADDR_WIDTH-1:0];
   assign imem_wdata = word_buf;
   assign core_run   = (state == DONE);
   assign load_done  = (state == DONE);
   assign load_error = (state == ERROR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: good, bad and boundary images with a write logger.
module tb_imem_boot_loader;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        core_run;
   logic        load_done;
   logic        load_error;

   int errors = 0;
   int checks = 0;

   logic [7:0]  wr_addr_log [0:1023];
   logic [31:0] wr_data_log [0:1023];
   int          wr_count = 0;
   logic        both_seen = 1'b0;

   imem_boot_loader #(.ADDR_WIDTH(8)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_run   (core_run),
      .load_done  (load_done),
      .load_error (load_error)
   );

   always #5 clock = ~clock;

   // Each WRITE cycle contains exactly one falling edge, so each write is logged once.
   always @(negedge clock) begin
      if (imem_we && wr_count < 1024) begin
         wr_addr_log[wr_count] = imem_addr;
         wr_data_log[wr_count] = imem_wdata;
      end
      if (imem_we) wr_count = wr_count + 1;
      if (load_done && load_error) both_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Entered and left at a falling edge; waits (bounded) until the byte is taken.
   task automatic send_byte(input logic [7:0] b);
      int budget;
      budget = 50;
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready) begin
         @(negedge clock);
         budget--;
         if (budget == 0) begin
            check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
            break;
         end
      end
      @(negedge clock);
   endtask

   task automatic idle_cycle();
      rx_valid = 1'b0;
      @(negedge clock);
   endtask

   task automatic send_word(input logic [31:0] w, input bit gaps);
      for (int i = 3; i >= 0; i--) begin
         send_byte(w[8*i +: 8]);
         if (gaps) idle_cycle();
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rx_ready"},   {31'd0, rx_ready},   32'd0);
      check({tag, "_imem_we"},    {31'd0, imem_we},    32'd0);
      check({tag, "_imem_addr"},  {24'd0, imem_addr},  32'd0);
      check({tag, "_imem_wdata"}, imem_wdata,          32'd0);
      check({tag, "_core_run"},   {31'd0, core_run},   32'd0);
      check({tag, "_load_done"},  {31'd0, load_done},  32'd0);
      check({tag, "_load_error"}, {31'd0, load_error}, 32'd0);
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      @(negedge clock);
      #1 reset_n = 1'b0;
      #1 check_all_zero("reset");
      #2 reset_n = 1'b1;
      @(negedge clock);
   endtask

   initial begin
      int base;
      int seq_bad;

      // Power-on reset
      #1 check_all_zero("por");
      #10 reset_n = 1'b1;
      @(negedge clock);
      check("por_ready", {31'd0, rx_ready}, 32'd1);

      // Single word, valid held high
      base = wr_count;
      send_byte(8'h00); send_byte(8'h01);
      send_word(32'hDEADBEEF, 1'b0);
      check("w1_we",   {31'd0, imem_we}, 32'd1);
      check("w1_addr", {24'd0, imem_addr}, 32'd0);
      check("w1_data", imem_wdata, 32'hDEADBEEF);
      send_byte(8'h22);
      rx_valid = 1'b0;
      check("w1_run",   {31'd0, core_run},   32'd1);
      check("w1_done",  {31'd0, load_done},  32'd1);
      check("w1_err",   {31'd0, load_error}, 32'd0);
      check("w1_ready", {31'd0, rx_ready},   32'd0);
      rx_valid = 1'b1; rx_data = 8'h55;
      repeat (3) @(negedge clock);
      rx_valid = 1'b0;
      check("w1_hold_done", {31'd0, load_done}, 32'd1);
      check("w1_wr_count", wr_count - base, 32'd1);

      // Three words, valid toggling
      do_reset();
      base = wr_count;
      send_byte(8'h00); idle_cycle();
      send_byte(8'h03); idle_cycle();
      send_word(32'h00000001, 1'b1);
      send_word(32'h00000002, 1'b1);
      send_word(32'h00000003, 1'b1);
      send_byte(8'h00); idle_cycle();
      check("w3_wr_count", wr_count - base, 32'd3);
      for (int k = 0; k < 3; k++) begin
         check("w3_addr", {24'd0, wr_addr_log[base + k]}, k);
         check("w3_data", wr_data_log[base + k], k + 1);
      end
      check("w3_done", {31'd0, load_done}, 32'd1);
      check("w3_run",  {31'd0, core_run},  32'd1);

      // Bad checksum
      do_reset();
      base = wr_count;
      send_byte(8'h00); send_byte(8'h01);
      send_word(32'hDEADBEEF, 1'b0);
      send_byte(8'h23);
      rx_valid = 1'b0;
      check("bc_wr_count", wr_count - base, 32'd1);
      check("bc_addr", {24'd0, wr_addr_log[base]}, 32'd0);
      check("bc_data", wr_data_log[base], 32'hDEADBEEF);
      check("bc_err",   {31'd0, load_error}, 32'd1);
      check("bc_run",   {31'd0, core_run},   32'd0);
      check("bc_done",  {31'd0, load_done},  32'd0);
      check("bc_ready", {31'd0, rx_ready},   32'd0);

      // Bad header N=0
      do_reset();
      base = wr_count;
      send_byte(8'h00); send_byte(8'h00);
      rx_valid = 1'b0;
      check("n0_err", {31'd0, load_error}, 32'd1);
      check("n0_ready", {31'd0, rx_ready}, 32'd0);
      repeat (3) @(negedge clock);
      check("n0_wr_count", wr_count - base, 32'd0);

      // Bad header N=257
      do_reset();
      base = wr_count;
      send_byte(8'h01); send_byte(8'h01);
      rx_valid = 1'b0;
      check("n257_err", {31'd0, load_error}, 32'd1);
      repeat (3) @(negedge clock);
      check("n257_wr_count", wr_count - base, 32'd0);

      // Full depth, N=256, word k = k; checksum is XOR of 0..255 = 0
      do_reset();
      base = wr_count;
      send_byte(8'h01); send_byte(8'h00);
      for (int k = 0; k < 256; k++) send_word(k, 1'b0);
      send_byte(8'h00);
      rx_valid = 1'b0;
      check("fd_wr_count", wr_count - base, 32'd256);
      seq_bad = 0;
      for (int k = 0; k < 256; k++)
         if (wr_addr_log[base + k] !== 8'(k) || wr_data_log[base + k] !== k) seq_bad++;
      check("fd_sequence", seq_bad, 32'd0);
      check("fd_last_addr", {24'd0, wr_addr_log[base + 255]}, 32'd255);
      check("fd_last_data", wr_data_log[base + 255], 32'h000000FF);
      check("fd_done", {31'd0, load_done}, 32'd1);

      // Reset after two payload bytes, then a clean reload
      do_reset();
      send_byte(8'h00); send_byte(8'h01);
      send_byte(8'hAA); send_byte(8'hBB);
      rx_valid = 1'b0;
      check("mid_partial", imem_wdata, 32'h0000AABB);
      do_reset();
      check("mid_restart_ready", {31'd0, rx_ready}, 32'd1);
      base = wr_count;
      send_byte(8'h00); send_byte(8'h01);
      send_word(32'h12345678, 1'b0);
      send_byte(8'h08);
      rx_valid = 1'b0;
      check("mid_wr_count", wr_count - base, 32'd1);
      check("mid_addr", {24'd0, wr_addr_log[base]}, 32'd0);
      check("mid_data", wr_data_log[base], 32'h12345678);
      check("mid_done", {31'd0, load_done}, 32'd1);
      check("mid_run",  {31'd0, core_run},  32'd1);

      check("done_and_error_exclusive", {31'd0, both_seen}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
